// File: rtl/hack_seq_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : hack_seq_controller
// Description : Multi-cycle Hack CPU control path: fetch into IR, optional
//               M read, one execute cycle, optional M write.
// Revision    : 1.0 - initial release
// ============================================================================
module hack_seq_controller #(
    parameter int WIDTH      = 16,
    parameter int RD_TIMEOUT = 0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] instruction_i,
    input  logic             instr_valid_i,
    output logic             instr_ready_o,
    input  logic             zn_i,
    input  logic             zr_i,
    output logic             mem_req_o,
    output logic             mem_we_o,
    input  logic             mem_ack_i,
    output logic             enA_o,
    output logic             enD_o,
    output logic             selA_o,
    output logic             selALU_o,
    output logic             za_o,
    output logic             na_o,
    output logic             zb_o,
    output logic             nb_o,
    output logic             f_o,
    output logic             no_o,
    output logic             loadPC_o,
    output logic             incPC_o,
    output logic             busy_o,
    output logic             err_o
);

    localparam logic [1:0] c_ST_FETCH   = 2'd0;
    localparam logic [1:0] c_ST_RD_WAIT = 2'd1;
    localparam logic [1:0] c_ST_EXEC    = 2'd2;
    localparam logic [1:0] c_ST_WR_WAIT = 2'd3;

    logic [1:0]       r_state;
    logic [1:0]       w_next;
    logic [WIDTH-1:0] r_ir;
    logic             r_err;
    logic             w_timeout;
    logic             w_is_c;
    logic             w_jump;
    logic             w_unused_ir;

    assign w_is_c      = r_ir[WIDTH-1];
    assign w_jump      = w_is_c & ((zn_i & r_ir[2]) | (zr_i & r_ir[1]) |
                                   (r_ir[0] & ~zn_i & ~zr_i));
    assign w_unused_ir = &{1'b0, r_ir[WIDTH-2:13]};

    generate
        if (RD_TIMEOUT > 0) begin : g_timeout
            localparam int c_CNT_W = (RD_TIMEOUT > 1) ? $clog2(RD_TIMEOUT) : 1;
            localparam logic [c_CNT_W-1:0] c_TO_LAST = c_CNT_W'(RD_TIMEOUT - 1);
            logic [c_CNT_W-1:0] r_rd_cnt;

            // Counts completed read-wait cycles; restarts on every exit.
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    r_rd_cnt <= '0;
                end else if (r_state == c_ST_RD_WAIT && !mem_ack_i && !w_timeout) begin
                    r_rd_cnt <= r_rd_cnt + c_CNT_W'(1);
                end else begin
                    r_rd_cnt <= '0;
                end
            end

            assign w_timeout = (r_state == c_ST_RD_WAIT) && (r_rd_cnt == c_TO_LAST);
        end else begin : g_no_timeout
            assign w_timeout = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= c_ST_FETCH;
            r_ir    <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == c_ST_FETCH && instr_valid_i) begin
                r_ir <= instruction_i;
            end
            // A genuine ack in the final cycle is not an error.
            if (w_timeout && !mem_ack_i) begin
                r_err <= 1'b1;
            end
        end
    end

    always_comb begin
        w_next        = r_state;
        instr_ready_o = 1'b0;
        mem_req_o     = 1'b0;
        mem_we_o      = 1'b0;
        enA_o         = 1'b0;
        enD_o         = 1'b0;
        selA_o        = 1'b0;
        selALU_o      = 1'b0;
        {za_o, na_o, zb_o, nb_o, f_o, no_o} = 6'b0;
        loadPC_o      = 1'b0;
        incPC_o       = 1'b0;

        case (r_state)
            c_ST_FETCH: begin
                instr_ready_o = 1'b1;
                if (instr_valid_i) begin
                    w_next = (instruction_i[WIDTH-1] & instruction_i[12]) ?
                             c_ST_RD_WAIT : c_ST_EXEC;
                end
            end
            c_ST_RD_WAIT: begin
                mem_req_o = 1'b1;
                selALU_o  = 1'b1;
                if (mem_ack_i || w_timeout) begin
                    w_next = c_ST_EXEC;
                end
            end
            c_ST_EXEC: begin
                selA_o   = ~w_is_c;
                selALU_o = r_ir[12];
                {za_o, na_o, zb_o, nb_o, f_o, no_o} = r_ir[11:6];
                enA_o    = r_ir[5] | ~w_is_c;
                enD_o    = r_ir[4] & w_is_c;
                loadPC_o = w_jump;
                incPC_o  = ~w_jump;
                w_next   = (w_is_c & r_ir[3]) ? c_ST_WR_WAIT : c_ST_FETCH;
            end
            c_ST_WR_WAIT: begin
                // ALU operand select and function stay put so write data is stable.
                mem_req_o = 1'b1;
                mem_we_o  = 1'b1;
                selALU_o  = r_ir[12];
                {za_o, na_o, zb_o, nb_o, f_o, no_o} = r_ir[11:6];
                if (mem_ack_i) begin
                    w_next = c_ST_FETCH;
                end
            end
            default: begin
                w_next = c_ST_FETCH;
            end
        endcase
    end

    assign busy_o = (r_state != c_ST_FETCH);
    assign err_o  = r_err;

endmodule
`default_nettype wire
